mult_par_pipe: RTL and testbench

Parametrised signed multiplier with even-parity argument checking, req/ack handshake and configurable result latency. It generalises the team's fixed 16x16 multiplier DUT to any operand width and pipeline depth, with an optional saturating parity-error counter. It sits behind the same req/ack/result_rdy protocol the mult_bfm testbench drives, so existing benches retarget by changing parameters.

---
 rtl/mult_pkg.sv | 19 +
 rtl/mult_par_delay.sv | 46 ++++
 rtl/mult_par_pipe.sv | 140 ++++++++++++++
 tb/tb_mult_par_pipe.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and helpers for the parity-checked multiplier
//   state_t  : handshake FSM states (IDLE, BUSY)
//   parity() : even parity (reduction XOR) of a zero-extended vector up to PAR_MAX_W bits
package mult_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Zero-extension leaves XOR parity unchanged, so one fixed-width
    // function serves every operand and result width up to this size.
    localparam int PAR_MAX_W = 128;

    function automatic logic parity(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/mult_par_delay.sv
// rtl/mult_par_delay.sv - LATENCY-deep valid/data/error delay line
//   clk, rst                         : clock, synchronous active-high reset
//   in_valid, in_data, in_err        : stage-0 inputs, sampled every edge
//   out_valid, out_data, out_err     : values presented LATENCY edges earlier
module mult_par_delay #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    logic [LATENCY-1:0] valid_q;
    logic [LATENCY-1:0] err_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            err_q[0]   <= in_err;
            data_q[0]  <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                data_q[i]  <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_err   = err_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/mult_par_pipe.sv
// rtl/mult_par_pipe.sv - signed multiplier with argument parity check and req/ack handshake; MULT_PAR_ERR_CNT_EN adds err_cnt
//   clk, rst                    : clock, synchronous active-high reset
//   req                         : request, sampled only in IDLE
//   arg_a/arg_b (+ _parity)     : signed operands with even parity bits
//   ack                         : one-cycle pulse, request accepted
//   result, result_parity       : 2*DATA_W signed product (0 on parity error) and its parity
//   result_rdy                  : one-cycle pulse, result valid
//   arg_parity_error            : last loaded result came from bad parity
//   err_cnt                     : saturating parity-error count (MULT_PAR_ERR_CNT_EN only)
module mult_par_pipe
    import mult_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LATENCY   = 2,
    parameter int ERR_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [DATA_W-1:0]     arg_a,
    input  logic                  arg_a_parity,
    input  logic [DATA_W-1:0]     arg_b,
    input  logic                  arg_b_parity,
    output logic                  ack,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_parity,
    output logic                  result_rdy,
    output logic                  arg_parity_error
`ifdef MULT_PAR_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0]  err_cnt
`endif
);

    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(LATENCY + 1);

    // Degenerate parameter sets; the block is intentionally empty.
    localparam bit CFG_OK = (DATA_W >= 2) && (LATENCY >= 1) && (ERR_CNT_W >= 1)
                            && (RES_W <= PAR_MAX_W);
    if (!CFG_OK) begin : g_bad_cfg
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               accept;
    logic               load;

    // Product is formed from the operands as they are accepted and then
    // carried through the delay line; sign-extending both operands to the
    // full result width makes the truncated RES_W product exact.
    logic signed [RES_W-1:0] a_ext, b_ext, prod_full;
    logic                    cap_err;
    logic [RES_W-1:0]        cap_data;

    assign a_ext     = {{DATA_W{arg_a[DATA_W-1]}}, arg_a};
    assign b_ext     = {{DATA_W{arg_b[DATA_W-1]}}, arg_b};
    assign prod_full = a_ext * b_ext;
    assign cap_err   = (arg_a_parity != parity(PAR_MAX_W'(arg_a)))
                     | (arg_b_parity != parity(PAR_MAX_W'(arg_b)));
    assign cap_data  = cap_err ? '0 : prod_full;

    logic             dl_valid;
    logic [RES_W-1:0] dl_data;
    logic             dl_err;

    mult_par_delay #(
        .DATA_W  (RES_W),
        .LATENCY (LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_data   (cap_data),
        .in_err    (cap_err),
        .out_valid (dl_valid),
        .out_data  (dl_data),
        .out_err   (dl_err)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Delay line and counter expire on the same edge; the
                    // valid bit guards against loading a flushed entry.
                    load    = dl_valid;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            ack              <= 1'b0;
            result_rdy       <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack        <= accept;
            result_rdy <= load;
            if (load) begin
                result           <= dl_data;
                result_parity    <= parity(PAR_MAX_W'(dl_data));
                arg_parity_error <= dl_err;
            end
        end
    end

`ifdef MULT_PAR_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (load && dl_err && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_mult_par_pipe.sv
// tb/tb_mult_par_pipe.sv - directed bench for mult_par_pipe at LATENCY 2 and 3
module tb_mult_par_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req2 = 1'b0, ap2 = 1'b0, bp2 = 1'b0;
    logic [15:0] a2 = '0, b2 = '0;
    logic        ack2, rp2, rdy2, pe2;
    logic [31:0] res2;

    logic        req3 = 1'b0, ap3 = 1'b0, bp3 = 1'b0;
    logic [15:0] a3 = '0, b3 = '0;
    logic        ack3, rp3, rdy3, pe3;
    logic [31:0] res3;

`ifdef MULT_PAR_ERR_CNT_EN
    logic [1:0]  ec2, ec3;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mult_par_pipe #(.DATA_W(16), .LATENCY(2), .ERR_CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .req(req2),
        .arg_a(a2), .arg_a_parity(ap2), .arg_b(b2), .arg_b_parity(bp2),
        .ack(ack2), .result(res2), .result_parity(rp2), .result_rdy(rdy2),
        .arg_parity_error(pe2)
`ifdef MULT_PAR_ERR_CNT_EN
        , .err_cnt(ec2)
`endif
    );

    mult_par_pipe #(.DATA_W(16), .LATENCY(3), .ERR_CNT_W(2)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3),
        .arg_a(a3), .arg_a_parity(ap3), .arg_b(b3), .arg_b_parity(bp3),
        .ack(ack3), .result(res3), .result_parity(rp3), .result_rdy(rdy3),
        .arg_parity_error(pe3)
`ifdef MULT_PAR_ERR_CNT_EN
        , .err_cnt(ec3)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_tests++;
        if ({ack2, rdy2, rp2, pe2, res2} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_l2: ack=%b rdy=%b par=%b err=%b res=%h, required all 0",
                     ack2, rdy2, rp2, pe2, res2);
        end
        n_tests++;
        if ({ack3, rdy3, rp3, pe3, res3} !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_l3: ack=%b rdy=%b par=%b err=%b res=%h, required all 0",
                     ack3, rdy3, rp3, pe3, res3);
        end
`ifdef MULT_PAR_ERR_CNT_EN
        n_tests++;
        if (ec2 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_err_cnt: got %0d, required 0", ec2);
        end
`endif
    endtask

    // One LATENCY=2 transaction: ack after E, result_rdy only after E+2.
    task automatic test_op(input string name, input logic [15:0] a, input logic pa,
                           input logic [15:0] b, input logic pb,
                           input logic [31:0] exp_res, input logic exp_par,
                           input logic exp_err);
        a2 = a; ap2 = pa; b2 = b; bp2 = pb; req2 = 1'b1;
        tick();
        req2 = 1'b0;
        n_tests++;
        if (ack2 !== 1'b1 || rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_ack: ack=%b rdy=%b, required ack=1 rdy=0", name, ack2, rdy2);
        end
        tick();
        n_tests++;
        if (ack2 !== 1'b0 || rdy2 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_busy: ack=%b rdy=%b, required 0 0", name, ack2, rdy2);
        end
        tick();
        n_tests++;
        if (rdy2 !== 1'b1 || res2 !== exp_res || rp2 !== exp_par || pe2 !== exp_err) begin
            n_fail++;
            $display("FAIL %s_result: rdy=%b res=%h par=%b err=%b, required 1 %h %b %b",
                     name, rdy2, res2, rp2, pe2, exp_res, exp_par, exp_err);
        end
        tick();
        n_tests++;
        if (rdy2 !== 1'b0 || res2 !== exp_res || pe2 !== exp_err) begin
            n_fail++;
            $display("FAIL %s_hold: rdy=%b res=%h err=%b, required 0 %h %b",
                     name, rdy2, res2, pe2, exp_res, exp_err);
        end
    endtask

    task automatic test_multiply();
        test_op("pos_neg", 16'h0003, 1'b0, 16'hFFFE, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0);
        test_op("min_min", 16'h8000, 1'b1, 16'h8000, 1'b1, 32'h4000_0000, 1'b1, 1'b0);
        test_op("max_max", 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 32'h3FFF_0001, 1'b1, 1'b0);
    endtask

    task automatic test_parity_error();
        test_op("bad_a", 16'h0005, 1'b1, 16'h0007, 1'b1, 32'h0, 1'b0, 1'b1);
        test_op("clear", 16'hFFFF, 1'b0, 16'h0064, 1'b1, 32'hFFFF_FF9C, 1'b0, 1'b0);
        test_op("bad_b", 16'h0002, 1'b1, 16'h0003, 1'b1, 32'h0, 1'b0, 1'b1);
    endtask

    // LATENCY=3 with req held: accepts on edges 0, 4, 8; results after 3, 7.
    task automatic test_back_to_back();
        bit seen;
        a3 = 16'hFFFD; ap3 = 1'b1; b3 = 16'h0004; bp3 = 1'b1; req3 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (ack3 !== ((i % 4) == 0) || rdy3 !== ((i % 4) == 3)) begin
                n_fail++;
                $display("FAIL b2b_cycle%0d: ack=%b rdy=%b, required ack=%b rdy=%b",
                         i, ack3, rdy3, (i % 4) == 0, (i % 4) == 3);
            end
            if (i == 3) begin
                n_tests++;
                if (res3 !== 32'hFFFF_FFF4 || rp3 !== 1'b1 || pe3 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_result: res=%h par=%b err=%b, required fffffff4 1 0",
                             res3, rp3, pe3);
                end
            end
        end
        req3 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6 && !seen; i++) begin
            tick();
            if (rdy3) seen = 1'b1;
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL b2b_drain: result_rdy=0 within 6 cycles, required 1");
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        a2 = 16'h0003; ap2 = 1'b0; b2 = 16'h0003; bp2 = 1'b0; req2 = 1'b1;
        tick();
        req2 = 1'b0;
        n_tests++;
        if (ack2 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_ack: ack=%b, required 1", ack2);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if ({ack2, rdy2, rp2, pe2, res2} !== 36'd0) begin
                n_fail++;
                $display("FAIL midrst_idle%0d: ack=%b rdy=%b par=%b err=%b res=%h, required all 0",
                         i, ack2, rdy2, rp2, pe2, res2);
            end
            tick();
        end
        test_op("after_rst", 16'h0003, 1'b0, 16'h0003, 1'b0, 32'h0000_0009, 1'b0, 1'b0);
    endtask

`ifdef MULT_PAR_ERR_CNT_EN
    task automatic test_err_cnt();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            test_op("err_op", 16'h0005, 1'b1, 16'h0007, 1'b1, 32'h0, 1'b0, 1'b1);
            n_tests++;
            if (ec2 !== exp_cnt[i]) begin
                n_fail++;
                $display("FAIL err_cnt_%0d: got %0d, required %0d", i, ec2, exp_cnt[i]);
            end
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (ec2 !== 2'd0) begin
            n_fail++;
            $display("FAIL err_cnt_rst: got %0d, required 0", ec2);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_multiply();
        test_parity_error();
        test_back_to_back();
        test_reset_mid_op();
`ifdef MULT_PAR_ERR_CNT_EN
        test_err_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
